fwd_hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's two-operand EX forwarding logic.
- Tracks the destination tag of every in-flight instruction in an internal tag pipeline covering stages EX..(EX+DEPTH-1).
- Handles producers with different result-ready stages (ALU vs load).
- Detects load-use hazards in ID, raises `stall`, and registers per-operand forward selects aligned with the instruction entering EX.

---
 rtl/fwd_hazard_scoreboard_pkg.sv | 36 +++
 rtl/fwd_hazard_scoreboard_src_match.sv | 49 ++++
 rtl/fwd_hazard_scoreboard.sv | 103 ++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared types and constants for the forwarding / load-use hazard scoreboard.
// Tag entries are stored at fixed generous widths so the package stays
// parameter-free; register numbers up to 8 bits and DEPTH up to 256 fit.
package fwd_hazard_scoreboard_pkg;

  localparam int TAG_DST_W = 8;
  localparam int TAG_RDY_W = 8;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_REGFILE = 0;

  // Stage index at which a producer's result becomes forwardable.
  localparam int RDY_ALU  = 1;
  localparam int RDY_LOAD = 2;

  // One in-flight instruction: wr is already cleared for dst==0.
  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [TAG_DST_W-1:0] dst;
    logic [TAG_RDY_W-1:0] rdy;
  } tag_t;

  // Clamp a requested ready stage into 1..depth-1 (0 is treated as ALU).
  function automatic logic [TAG_RDY_W-1:0] sat_rdy(input int unsigned rdy,
                                                   input int unsigned depth);
    if (rdy == 0) begin
      return TAG_RDY_W'(RDY_ALU);
    end
    if (rdy >= depth) begin
      return TAG_RDY_W'(depth - 1);
    end
    return TAG_RDY_W'(rdy);
  endfunction

endpackage

// File: rtl/fwd_hazard_scoreboard_src_match.sv
// Per-operand youngest-producer search over the tag pipeline.
// Returns whether the operand must stall and, if not, which stage to forward
// from next cycle (0 = register file).
module fwd_src_match
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = $clog2(DEPTH)
) (
  input  tag_t [DEPTH-1:0]   tags,
  input  logic               en,
  input  logic [REG_AW-1:0]  src,
  output logic               stall_s,
  output logic [SEL_W-1:0]   sel_s
);

  logic                 hit;
  int                   hit_idx;
  logic [TAG_RDY_W-1:0] hit_rdy;

  // Scan oldest to youngest so the smallest matching index overwrites the rest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 0;
    hit_rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (tags[i].valid && tags[i].wr && (tags[i].dst == TAG_DST_W'(src))) begin
        hit     = 1'b1;
        hit_idx = i;
        hit_rdy = tags[i].rdy;
      end
    end
  end

  // A producer leaving the tracked window is already in the register file.
  always_comb begin
    stall_s = 1'b0;
    sel_s   = SEL_W'(FWD_REGFILE);
    if (en && hit && (hit_idx + 1 < DEPTH)) begin
      if (hit_idx + 1 < int'(hit_rdy)) begin
        stall_s = 1'b1;
      end else begin
        sel_s = SEL_W'(hit_idx + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard scoreboard for the ID/EX boundary.
// Tracks destination tags of in-flight instructions (EX..EX+DEPTH-1), raises a
// combinational stall on load-use hazards and registers forward selects that
// line up with the instruction entering EX.
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = $clog2(DEPTH),
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic                       flush_id,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [REG_AW-1:0]          id_dst,
  input  logic                       id_reg_write,
  input  logic [SEL_W-1:0]           id_rdy,
  output logic                       stall,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       ex_bubble,
  output logic [CNT_W-1:0]           stall_count
);

  tag_t [DEPTH-1:0]         tag_reg;
  tag_t                     new_tag;
  logic [NUM_SRC-1:0]       src_en;
  logic [NUM_SRC-1:0]       stall_vec;
  logic [NUM_SRC*SEL_W-1:0] sel_vec;
  logic                     issue;

  // One search per operand; flush and unused/r0 operands never stall.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_en[gi] = id_valid & id_src_used[gi] & ~flush_id &
                          (id_src[gi*REG_AW +: REG_AW] != '0);

      fwd_src_match #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
      ) u_match (
        .tags    (tag_reg),
        .en      (src_en[gi]),
        .src     (id_src[gi*REG_AW +: REG_AW]),
        .stall_s (stall_vec[gi]),
        .sel_s   (sel_vec[gi*SEL_W +: SEL_W])
      );
    end
  endgenerate

  assign stall = |stall_vec;
  assign issue = id_valid & ~flush_id & ~stall;

  // Build the tag for the instruction leaving ID; writes to r0 never forward.
  always_comb begin
    new_tag       = '0;
    new_tag.valid = 1'b1;
    new_tag.wr    = id_reg_write & (id_dst != '0);
    new_tag.dst   = TAG_DST_W'(id_dst);
    new_tag.rdy   = sat_rdy(32'(id_rdy), DEPTH);
  end

  // Tag pipeline always advances; a stall or flush only injects an empty slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_reg <= '0;
    end else begin
      tag_reg[0] <= issue ? new_tag : '0;
      for (int i = 1; i < DEPTH; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  // EX-aligned forward selects and bubble flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_sel   <= '0;
      ex_bubble <= 1'b1;
    end else if (issue) begin
      fwd_sel   <= sel_vec;
      ex_bubble <= 1'b0;
    end else begin
      fwd_sel   <= '0;
      ex_bubble <= 1'b1;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: directed pipeline scenarios
// followed by random traffic, checked against a per-register last-writer model.
module tb_fwd_hazard_scoreboard;

  localparam int NS    = 2;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int SW    = 2;
  // Narrow counter so saturation is reached in a few thousand cycles.
  localparam int CW    = 12;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int NEVER = -1;

  logic              clk;
  logic              reset;
  logic              id_valid;
  logic              flush_id;
  logic [NS*AW-1:0]  id_src;
  logic [NS-1:0]     id_src_used;
  logic [AW-1:0]     id_dst;
  logic              id_reg_write;
  logic [SW-1:0]     id_rdy;
  logic              stall;
  logic [NS*SW-1:0]  fwd_sel;
  logic              ex_bubble;
  logic [CW-1:0]     stall_count;

  fwd_hazard_scoreboard #(
    .NUM_SRC (NS),
    .REG_AW  (AW),
    .DEPTH   (DEPTH),
    .SEL_W   (SW),
    .CNT_W   (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .flush_id     (flush_id),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_rdy       (id_rdy),
    .stall        (stall),
    .fwd_sel      (fwd_sel),
    .ex_bubble    (ex_bubble),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: for every register, the cycle its youngest writer left ID and that
  // writer's ready stage. Distance in cycles equals the stage it will occupy.
  int cyc;
  int last_acc [32];
  int last_rdy [32];
  int exp_fwd  [NS];
  int exp_bub;
  int exp_cnt;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      last_acc[r] = NEVER;
      last_rdy[r] = 0;
    end
    for (int s = 0; s < NS; s++) exp_fwd[s] = 0;
    exp_bub = 1;
    exp_cnt = 0;
  endtask

  function automatic int sat_ready(input int r);
    if (r == 0) return 1;
    if (r >= DEPTH) return DEPTH - 1;
    return r;
  endfunction

  task automatic model_src(input int src, input bit en, output bit st, output int sel);
    int d;
    st  = 1'b0;
    sel = 0;
    if (en && src != 0 && last_acc[src] != NEVER) begin
      d = cyc - last_acc[src];
      if (d < DEPTH) begin
        if (d < last_rdy[src]) st = 1'b1;
        else sel = d;
      end
    end
  endtask

  // One ID cycle: drive, check combinational and registered outputs, advance model.
  task automatic step(input string name, input bit v, input bit f,
                      input int s0, input int s1, input bit [1:0] used,
                      input int dst, input bit wr, input int rdy);
    int  src [NS];
    bit  st  [NS];
    int  sel [NS];
    bit  exp_stall;
    @(negedge clk);
    id_valid     = v;
    flush_id     = f;
    id_src       = {AW'(s1), AW'(s0)};
    id_src_used  = used;
    id_dst       = AW'(dst);
    id_reg_write = wr;
    id_rdy       = SW'(rdy);
    #1;
    src[0] = s0;
    src[1] = s1;
    exp_stall = 1'b0;
    for (int s = 0; s < NS; s++) begin
      model_src(src[s], v && used[s] && !f, st[s], sel[s]);
      exp_stall = exp_stall | st[s];
    end
    check("stall", stall, exp_stall);
    for (int s = 0; s < NS; s++) check($sformatf("fwd_sel%0d", s), fwd_sel[s*SW +: SW], exp_fwd[s]);
    check("ex_bubble", ex_bubble, exp_bub);
    check("stall_count", stall_count, exp_cnt);
    if (name != "")
      $display("%0t %-12s v=%0b f=%0b src=%0d/%0d used=%b dst=%0d wr=%0b rdy=%0d | stall=%0b fwd=%0h bub=%0b cnt=%0d",
               $time, name, v, f, s0, s1, used, dst, wr, rdy, stall, fwd_sel, ex_bubble, stall_count);
    if (v && !f && !exp_stall) begin
      if (wr && dst != 0) begin
        last_acc[dst] = cyc;
        last_rdy[dst] = sat_ready(rdy);
      end
      for (int s = 0; s < NS; s++) exp_fwd[s] = sel[s];
      exp_bub = 0;
    end else begin
      for (int s = 0; s < NS; s++) exp_fwd[s] = 0;
      exp_bub = 1;
    end
    if (exp_stall && exp_cnt != CMAX) exp_cnt++;
    cyc++;
  endtask

  task automatic nop(input string name);
    step(name, 1'b0, 1'b0, 0, 0, 2'b00, 0, 1'b0, 0);
  endtask

  initial begin
    cyc = 10;
    model_clear();
    reset        = 1'b0;
    id_valid     = 1'b0;
    flush_id     = 1'b0;
    id_src       = '0;
    id_src_used  = '0;
    id_dst       = '0;
    id_reg_write = 1'b0;
    id_rdy       = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_fwd", fwd_sel, 0);
    check("rst_bubble", ex_bubble, 1);
    check("rst_count", stall_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // ALU back-to-back: add r3 then sub using r3 -> forward from MEM.
    step("add_r3", 1, 0, 1, 2, 2'b11, 3, 1, 1);
    step("sub_r3", 1, 0, 3, 0, 2'b01, 6, 1, 1);
    check("b2b_stall", stall, 0);
    nop("nop");
    check("b2b_sel", fwd_sel[0 +: SW], 1);

    // Distance 2 -> WB, distance 3 -> register file.
    step("add_r3", 1, 0, 1, 2, 2'b11, 3, 1, 1);
    nop("nop");
    step("use_r3", 1, 0, 3, 0, 2'b01, 8, 1, 1);
    nop("nop");
    check("dist2_sel", fwd_sel[0 +: SW], 2);
    step("add_r7", 1, 0, 1, 2, 2'b11, 7, 1, 1);
    nop("nop");
    nop("nop");
    step("use_r7", 1, 0, 7, 0, 2'b01, 8, 1, 1);
    nop("nop");
    check("dist3_sel", fwd_sel[0 +: SW], 0);

    // Load-use on operand 1: one stall cycle, then forward from WB.
    step("lw_r5", 1, 0, 1, 0, 2'b01, 5, 1, 2);
    step("add_rt_r5", 1, 0, 1, 5, 2'b11, 9, 1, 1);
    check("lu_stall", stall, 1);
    step("add_rt_r5", 1, 0, 1, 5, 2'b11, 9, 1, 1);
    check("lu_stall_end", stall, 0);
    check("lu_bubble", ex_bubble, 1);
    check("lu_count", stall_count, 1);
    nop("nop");
    check("lu_sel", fwd_sel[SW +: SW], 2);

    // Youngest producer wins: add r4 then lw r4.
    step("add_r4", 1, 0, 1, 2, 2'b11, 4, 1, 1);
    step("lw_r4", 1, 0, 1, 0, 2'b01, 4, 1, 2);
    step("use_r4", 1, 0, 4, 0, 2'b01, 11, 1, 1);
    check("yw_stall", stall, 1);
    step("use_r4", 1, 0, 4, 0, 2'b01, 11, 1, 1);
    check("yw_stall_end", stall, 0);
    nop("nop");
    check("yw_sel", fwd_sel[0 +: SW], 2);

    // r0 never forwards or stalls.
    step("lw_r0", 1, 0, 1, 0, 2'b01, 0, 1, 2);
    step("use_r0", 1, 0, 0, 0, 2'b11, 12, 1, 1);
    check("r0_stall", stall, 0);
    nop("nop");
    check("r0_sel", fwd_sel, 0);

    // Flush overrides a load-use hazard and the flushed instruction leaves no tag.
    step("lw_r9", 1, 0, 1, 0, 2'b01, 9, 1, 2);
    step("flush_use_r9", 1, 1, 9, 0, 2'b01, 10, 1, 1);
    check("flush_stall", stall, 0);
    step("use_r10", 1, 0, 10, 0, 2'b01, 13, 1, 1);
    check("flush_bubble", ex_bubble, 1);
    nop("nop");
    check("flush_no_tag", fwd_sel[0 +: SW], 0);

    // Random traffic over a small register set to provoke frequent hazards.
    for (int n = 0; n < 3000; n++) begin
      step("", ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset asserted during a stall clears everything immediately.
    step("lw_r5", 1, 0, 1, 0, 2'b01, 5, 1, 2);
    step("use_r5", 1, 0, 5, 0, 2'b01, 14, 1, 1);
    check("pre_rst_stall", stall, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_fwd", fwd_sel, 0);
    check("mid_rst_bubble", ex_bubble, 1);
    check("mid_rst_count", stall_count, 0);
    @(negedge clk);
    id_valid = 1'b0;
    flush_id = 1'b0;
    #1;
    check("in_rst_stall", stall, 0);
    reset = 1'b1;
    model_clear();

    // Saturation: one stall per load/use pair, well past the counter maximum.
    for (int n = 0; n < CMAX + 6; n++) begin
      step("", 1, 0, 1, 0, 2'b01, 5, 1, 2);
      step("", 1, 0, 0, 5, 2'b10, 6, 1, 1);
    end
    nop("nop");
    check("sat_count", stall_count, CMAX);
    nop("nop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
